// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit owning HI/LO: 32-step shift-add multiplier and restoring divider.
// Define MULDIV_DIV_EN to compile in the divider and DIV/DIVU; otherwise md_op 3/4 behave as NOP.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, PREP, CALC, FIX} state_t;

  state_t      state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic [63:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        sgn_q, sgn_d, neg_q, neg_d, done_q, done_d;
  logic [32:0] mul_sum;
  logic [63:0] prod;
`ifdef MULDIV_DIV_EN
  logic        div_q, div_d, rneg_q, rneg_d;
  logic [32:0] rem_sh;
  logic [31:0] diff, quo, rem;
  logic        ge;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sgn_d   = sgn_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    mul_sum = {1'b0, acc_q[63:32]} + (b_q[0] ? {1'b0, a_q} : 33'd0);
    prod    = neg_q ? (~acc_q + 64'd1) : acc_q;
`ifdef MULDIV_DIV_EN
    div_d   = div_q;
    rneg_d  = rneg_q;
    // Remainder lives in acc[63:32], quotient bits shift into acc[31:0], dividend bits come from a_q.
    rem_sh  = {acc_q[63:32], a_q[31]};
    ge      = rem_sh >= {1'b0, b_q};
    diff    = rem_sh[31:0] - b_q;
    quo     = neg_q  ? (~acc_q[31:0] + 32'd1)  : acc_q[31:0];
    rem     = rneg_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
`endif

    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          case (md_op)
            3'd1, 3'd2: begin
              a_d     = src_a;
              b_d     = src_b;
              sgn_d   = (md_op == 3'd1);
`ifdef MULDIV_DIV_EN
              div_d   = 1'b0;
`endif
              state_d = PREP;
            end
`ifdef MULDIV_DIV_EN
            3'd3, 3'd4: begin
              a_d     = src_a;
              b_d     = src_b;
              sgn_d   = (md_op == 3'd3);
              div_d   = 1'b1;
              state_d = PREP;
            end
`endif
            3'd5:    hi_d = src_a;
            3'd6:    lo_d = src_a;
            default: ;
          endcase
        end
      end
      PREP: begin
        neg_d = sgn_q & (a_q[31] ^ b_q[31]);
`ifdef MULDIV_DIV_EN
        rneg_d = sgn_q & a_q[31];
`endif
        if (sgn_q && a_q[31]) a_d = ~a_q + 32'd1;
        if (sgn_q && b_q[31]) b_d = ~b_q + 32'd1;
        acc_d   = 64'd0;
        cnt_d   = 5'd0;
        state_d = CALC;
      end
      CALC: begin
`ifdef MULDIV_DIV_EN
        if (div_q) begin
          acc_d = ge ? {diff, acc_q[30:0], 1'b1} : {rem_sh[31:0], acc_q[30:0], 1'b0};
          a_d   = {a_q[30:0], 1'b0};
        end else
`endif
        begin
          acc_d = {mul_sum, acc_q[31:1]};
          b_d   = {1'b0, b_q[31:1]};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = FIX;
      end
      FIX: begin
`ifdef MULDIV_DIV_EN
        // Divide by zero reports the raw loop outputs without sign correction.
        if (div_q) begin
          if (b_q == 32'd0) {hi_d, lo_d} = acc_q;
          else begin
            lo_d = quo;
            hi_d = rem;
          end
        end else
`endif
        {hi_d, lo_d} = prod;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (flush && state_q != IDLE) begin
      state_d = IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      acc_q   <= 64'd0;
      cnt_q   <= 5'd0;
      sgn_q   <= 1'b0;
      neg_q   <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      done_q  <= 1'b0;
`ifdef MULDIV_DIV_EN
      div_q   <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
`ifdef MULDIV_DIV_EN
      div_q   <= div_d;
      rneg_q  <= rneg_d;
`endif
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: vector table, random ops against an arithmetic model, corner sequences.
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;
  vec_t vecs[$];

  muldiv_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .md_op(md_op), .src_a(src_a),
    .src_b(src_b), .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic runs_calc(input logic [2:0] op);
`ifdef MULDIV_DIV_EN
    return (op >= 3'd1) && (op <= 3'd4);
`else
    return (op == 3'd1) || (op == 3'd2);
`endif
  endfunction

  // Architectural result {hi, lo} from plain arithmetic.
  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint p;
    int     sa, sb, q, r;
    logic [31:0] mag;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      3'd1: begin
        p = longint'(sa) * longint'(sb);
        return p;
      end
      3'd2: return {32'd0, a} * {32'd0, b};
      3'd3: begin
        if (b == 32'd0) begin
          mag = a[31] ? -a : a;
          return {mag, 32'hFFFFFFFF};
        end
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
        q = sa / sb;
        r = sa % sb;
        return {r, q};
      end
      3'd4: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
      default: return 64'd0;
    endcase
  endfunction

  task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo);
    int n;
    start = 1'b1; md_op = op; src_a = a; src_b = b;
    @(posedge clk); #1;
    start = 1'b0; md_op = 3'd0;
    check("done_clear", 64'(done), 64'd0);
    if (runs_calc(op)) begin
      check("busy_rise", 64'(busy), 64'd1);
      n = 0;
      while (busy && n < 60) begin
        @(posedge clk); #1;
        n++;
      end
      check("busy_cycles", 64'(n), 64'd34);
      check("done_pulse", 64'(done), 64'd1);
    end else begin
      check("busy_idle", 64'(busy), 64'd0);
    end
    check("hi", 64'(hi), 64'(ehi));
    check("lo", 64'(lo), 64'(elo));
    m_hi = ehi;
    m_lo = elo;
    $display("op=%0d a=%h b=%h hi=%h lo=%h", op, a, b, hi, lo);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b, eh, el;
    logic [63:0] r;
    int          seen_done;

    @(posedge clk); #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    vecs.push_back('{3'd1, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA});
    vecs.push_back('{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001});
    vecs.push_back('{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000});
    vecs.push_back('{3'd2, 32'd0,        32'h12345678, 32'd0,        32'd0});
    vecs.push_back('{3'd1, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001});
`ifdef MULDIV_DIV_EN
    vecs.push_back('{3'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD});
    vecs.push_back('{3'd4, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF});
    vecs.push_back('{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000});
    vecs.push_back('{3'd4, 32'hFFFFFFFF, 32'd16,       32'd15,       32'h0FFFFFFF});
    vecs.push_back('{3'd3, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD});
`else
    vecs.push_back('{3'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'h80000001});
    vecs.push_back('{3'd4, 32'd100,      32'd0,        32'hFFFFFFFF, 32'h80000001});
`endif
    vecs.push_back('{3'd0, 32'h11111111, 32'd5,        32'hFFFFFFFF, 32'h80000001});
    vecs.push_back('{3'd7, 32'h22222222, 32'd5,        32'hFFFFFFFF, 32'h80000001});
    foreach (vecs[i]) run_md(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ehi, vecs[i].elo);

    // MTLO then MTHI on consecutive cycles
    start = 1'b1; md_op = 3'd6; src_a = 32'h1234;
    @(posedge clk); #1;
    check("mt_busy0", 64'(busy), 64'd0);
    md_op = 3'd5; src_a = 32'hABCD;
    @(posedge clk); #1;
    start = 1'b0; md_op = 3'd0;
    check("mt_busy1", 64'(busy), 64'd0);
    check("mt_done", 64'(done), 64'd0);
    check("mtlo", 64'(lo), 64'h1234);
    check("mthi", 64'(hi), 64'hABCD);
    m_hi = 32'hABCD; m_lo = 32'h1234;
    $display("op=mtlo/mthi hi=%h lo=%h", hi, lo);

    // flush and MTHI in the same idle cycle
    start = 1'b1; md_op = 3'd5; src_a = 32'h5555; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0; md_op = 3'd0;
    check("flush_mthi", 64'(hi), 64'(m_hi));
    $display("op=flush+mthi hi=%h lo=%h", hi, lo);

    // flush a MULT in CALC
    start = 1'b1; md_op = 3'd1; src_a = 32'd9; src_b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i <= 10; i++) begin @(posedge clk); #1; end
    check("flush_busy_pre", 64'(busy), 64'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen_done++;
    end
    check("flush_no_done", 64'(seen_done), 64'd0);
    check("flush_hi", 64'(hi), 64'(m_hi));
    check("flush_lo", 64'(lo), 64'(m_lo));
    $display("op=flushed-mult hi=%h lo=%h", hi, lo);

    // random ops against the model; back-to-back issue in the done cycle
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(1, 6));
      a  = $urandom();
      b  = $urandom();
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: a = 32'h80000000;
        2: b = 32'hFFFFFFFF;
        3: b = $urandom_range(1, 20);
        default: ;
      endcase
      eh = m_hi; el = m_lo;
      if (runs_calc(op)) begin
        r = ref_result(op, a, b);
        eh = r[63:32]; el = r[31:0];
      end else if (op == 3'd5) eh = a;
      else if (op == 3'd6) el = a;
      run_md(op, a, b, eh, el);
    end

    // asynchronous reset in the middle of CALC
    start = 1'b1; md_op = 3'd1; src_a = 32'h1234567; src_b = 32'h89;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 15; i++) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    check("arst_hi", 64'(hi), 64'd0);
    check("arst_lo", 64'(lo), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("arst_busy_after", 64'(busy), 64'd0);
    check("arst_done_after", 64'(done), 64'd0);
    $display("op=async-reset hi=%h lo=%h", hi, lo);
    m_hi = 32'd0; m_lo = 32'd0;
    run_md(3'd2, 32'd6, 32'd7, 32'd0, 32'd42);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
